// File: rtl/m_dmem_resp_pkg.sv
// m_dmem_resp_pkg: shared state encodings, latency limits and address check
package m_dmem_resp_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;
    function automatic logic addr_err(input logic [31:0] addr, input int depth_log2);
        return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != 32'd0);
    endfunction
endpackage

// File: rtl/m_dmem_resp_if.sv
// m_dmem_resp_if: request/acknowledge load-store bus between core and data memory
interface m_dmem_resp_if;
    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_busy;
    modport master (
        output w_req, w_we, w_addr, w_wdata, w_be,
        input  w_ack, w_rdata, w_err, w_busy
    );
    modport slave (
        input  w_req, w_we, w_addr, w_wdata, w_be,
        output w_ack, w_rdata, w_err, w_busy
    );
endinterface

// File: rtl/m_dmem_array.sv
// m_dmem_array: word-organised synchronous RAM with byte write enables and registered read
module m_dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/m_dmem_resp.sv
// m_dmem_resp: data-memory responder with programmable latency, byte-enable stores and error flag
module m_dmem_resp
    import m_dmem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    m_dmem_resp_if.slave   bus
);
    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN : (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d, err_q, err_d, rd_ok_q, rd_ok_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              accept, fire, bad;
    logic [31:0]       ram_q;
    // fire marks the edge that enters RESP: memory access and response flags happen there
    always_comb begin
        accept  = (state_q == ST_IDLE) && bus.w_req;
        fire    = (state_q == ST_WAIT) && (cnt_q == '0);
        bad     = addr_err(addr_q, DEPTH_LOG2);
        state_d = accept ? ST_WAIT : fire ? ST_RESP : (state_q == ST_RESP) ? ST_IDLE : state_q;
        cnt_d   = accept ? CNT_LOAD : ((state_q == ST_WAIT) && (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
        ack_d   = fire;
        err_d   = fire && bad;
        rd_ok_d = fire && !bad && !we_q;
        we_d    = accept ? bus.w_we    : we_q;
        addr_d  = accept ? bus.w_addr  : addr_q;
        wdata_d = accept ? bus.w_wdata : wdata_q;
        be_d    = accept ? bus.w_be    : be_q;
    end
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end
    m_dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (w_clk),
        .addr  (addr_q[DEPTH_LOG2+1:2]),
        .be    ((fire && !bad && we_q) ? be_q : 4'b0000),
        .wdata (wdata_q),
        .re    (rd_ok_d),
        .rdata (ram_q)
    );
    assign bus.w_ack   = ack_q;
    assign bus.w_err   = err_q;
    assign bus.w_rdata = rd_ok_q ? ram_q : '0;
    assign bus.w_busy  = (state_q != ST_IDLE);
endmodule
